fir_decim: RTL



---
 rtl/fir_decim_if.sv | 36 +++
 rtl/fir_decim.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fir_decim_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_decim_if
// Purpose  : FIFO-side handshake and coefficient-load bundle for fir_decim.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_decim_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int NUM_TAPS    = 32
) ();
    localparam int c_ADDR_WIDTH = $clog2(NUM_TAPS);

    logic signed [DATA_WIDTH-1:0]  in_dout;
    logic                          in_empty;
    logic                          in_rd_en;
    logic signed [DATA_WIDTH-1:0]  out_din;
    logic                          out_full;
    logic                          out_wr_en;
    logic                          coeff_wr_en;
    logic [c_ADDR_WIDTH-1:0]       coeff_addr;
    logic signed [COEFF_WIDTH-1:0] coeff_din;
    logic                          busy;

    // master is the surrounding datapath (FIFOs + control), slave is the filter
    modport master (
        output in_dout, in_empty, out_full, coeff_wr_en, coeff_addr, coeff_din,
        input  in_rd_en, out_din, out_wr_en, busy
    );

    modport slave (
        input  in_dout, in_empty, out_full, coeff_wr_en, coeff_addr, coeff_din,
        output in_rd_en, out_din, out_wr_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_decim.sv
`default_nettype none
// ============================================================================
// Module   : fir_decim
// Purpose  : Sequential-MAC decimating FIR filter with runtime coefficients.
// Revision : 1.0 - initial release
// ============================================================================
module fir_decim #(
    parameter int NUM_TAPS    = 32,
    parameter int DECIMATION  = 1,
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int FRAC_BITS   = 10
) (
    input  wire logic  clock,
    input  wire logic  reset,
    fir_decim_if.slave bus
);
    localparam int c_ADDR_WIDTH = $clog2(NUM_TAPS);
    localparam int c_CNT_WIDTH  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int c_PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int c_ACC_WIDTH  = c_PROD_WIDTH + $clog2(NUM_TAPS);
    localparam logic [c_CNT_WIDTH-1:0]  c_LAST_SAMPLE = c_CNT_WIDTH'(DECIMATION - 1);
    localparam logic [c_ADDR_WIDTH-1:0] c_LAST_TAP    = c_ADDR_WIDTH'(NUM_TAPS - 1);
    localparam logic [c_ADDR_WIDTH:0]   c_NUM_TAPS    = (c_ADDR_WIDTH + 1)'(NUM_TAPS);

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [DATA_WIDTH-1:0]  r_hist [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] r_coef [NUM_TAPS];
    logic [c_CNT_WIDTH-1:0]        r_cnt;
    logic [c_ADDR_WIDTH-1:0]       r_tap;
    logic signed [c_ACC_WIDTH-1:0] r_acc;
    logic signed [DATA_WIDTH-1:0]  r_out;
    logic                          r_busy;

    logic                          w_rd_en;
    logic                          w_wr_en;
    logic                          w_coef_we;
    logic signed [c_PROD_WIDTH-1:0] w_prod;
    logic signed [c_ACC_WIDTH-1:0]  w_acc_next;
    logic signed [DATA_WIDTH-1:0]   w_scaled;

    assign w_prod     = r_coef[r_tap] * r_hist[r_tap];
    assign w_acc_next = r_acc + {{(c_ACC_WIDTH - c_PROD_WIDTH){w_prod[c_PROD_WIDTH-1]}}, w_prod};
    // arithmetic shift floors toward -inf; the narrowing cast wraps rather than saturates
    assign w_scaled   = DATA_WIDTH'(w_acc_next >>> FRAC_BITS);

    // coefficients may only change between blocks, before the first sample is taken
    assign w_coef_we = bus.coeff_wr_en && !r_busy && (r_state == S_READ) &&
                       (r_cnt == '0) && ({1'b0, bus.coeff_addr} < c_NUM_TAPS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_READ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // strobes are gated with reset so they fall the moment reset rises
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            S_READ: begin
                w_rd_en = !bus.in_empty && !reset;
                if (w_rd_en && (r_cnt == c_LAST_SAMPLE)) begin
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (r_tap == c_LAST_TAP) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_wr_en = !bus.out_full && !reset;
                if (w_wr_en) begin
                    w_state_next = S_READ;
                end
            end
            default: w_state_next = S_READ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tap  <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_busy <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_hist[k] <= '0;
                r_coef[k] <= '0;
            end
        end else begin
            if (w_coef_we) begin
                r_coef[bus.coeff_addr] <= bus.coeff_din;
            end
            case (r_state)
                S_READ: begin
                    if (w_rd_en) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) begin
                            r_hist[k] <= r_hist[k-1];
                        end
                        r_hist[0] <= bus.in_dout;
                        r_busy    <= 1'b1;
                        if (r_cnt == c_LAST_SAMPLE) begin
                            r_cnt <= '0;
                            r_acc <= '0;
                            r_tap <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_tap <= r_tap + 1'b1;
                    if (r_tap == c_LAST_TAP) begin
                        r_out <= w_scaled;
                    end
                end
                S_WRITE: begin
                    if (w_wr_en) begin
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_rd_en  = w_rd_en;
    assign bus.out_wr_en = w_wr_en;
    assign bus.out_din   = r_out;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire
